mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 10 +
 rtl/mem_bus_fsm.sv | 67 ++++++
 rtl/mem_stage.sv | 70 +++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: MEMctrl bit positions and memory-stage FSM states shared by decoder, EXE and MEM
package mem_pkg;
  localparam int MC_RD = 0;
  localparam int MC_WR = 1;
  localparam int MC_IO = 2;
  localparam int MC_WORD = 3;
  localparam int MC_ADDR_SEL = 4;
  localparam int MC_W = 7;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} mem_state_e;
endpackage

// File: rtl/mem_bus_fsm.sv
// mem_bus_fsm: byte-serial bus sequencer with read-byte capture and stall generation
module mem_bus_fsm
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic        io,
  input  logic        word,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] result,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_wr,
  output logic        bus_io,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        stall,
  output logic [15:0] data_out
);
  mem_state_e state_q, state_d;
  logic [7:0] lo_q, lo_d, hi_q, hi_d;
  logic access;
  assign access = rd | wr;
  // state and captured read bytes; reset abandons any bus transaction in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  // next state and byte capture; acks outside LO/HI are ignored
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    hi_d = hi_q;
    case (state_q)
      IDLE: state_d = access ? LO : IDLE;
      LO: if (bus_ack) begin
        lo_d = bus_rdata;
        state_d = word ? HI : DONE;
      end
      HI: if (bus_ack) begin
        hi_d = bus_rdata;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // bus drive and stall come straight from the held EXE operands, so they stay stable until ack
  always_comb begin
    bus_req = state_q == LO || state_q == HI;
    bus_wr = wr & ~rd;
    bus_io = io;
    bus_addr = state_q == HI ? addr + 16'd1 : addr;
    bus_wdata = state_q == HI ? wdata[15:8] : wdata[7:0];
    stall = bus_req | (state_q == IDLE & access);
    data_out = (state_q == DONE && rd) ? (word ? {hi_q, lo_q} : {8'h00, lo_q}) : result;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage; operand muxing and WB pass-through (debug ports under MEM_STAGE_DEBUG_EN)
module mem_stage
  import mem_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  Wr_id_in,
  input  logic [7:0]  Fmask_in,
  input  logic [7:0]  Flags_in,
  input  logic [6:0]  MEMctrl_in,
  input  logic [15:0] Result_in,
  input  logic [15:0] Src1_in,
  input  logic [15:0] seqNPC_in,
  input  logic        EOI_in,
  output logic        bus_req,
  output logic        bus_wr,
  output logic        bus_io,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        stall_out,
`ifdef MEM_STAGE_DEBUG_EN
  input  logic [38:0] DEBUG_uop,
  output logic [38:0] DEBUG_uop_out,
  input  logic        DEBUG_taken,
  output logic        DEBUG_taken_out,
`endif
  output logic [4:0]  Wr_id_out,
  output logic [7:0]  Fmask_out,
  output logic [7:0]  Flags_out,
  output logic [15:0] seqNPC_out,
  output logic        EOI_out,
  output logic [15:0] Data_out
);
  logic [15:0] addr, wdata;
  logic unused_ctrl;
  assign unused_ctrl = ^MEMctrl_in[6:5];
  assign addr = MEMctrl_in[MC_ADDR_SEL] ? Src1_in : Result_in;
  assign wdata = MEMctrl_in[MC_ADDR_SEL] ? Result_in : Src1_in;
  assign Wr_id_out = Wr_id_in;
  assign Fmask_out = Fmask_in;
  assign Flags_out = Flags_in;
  assign seqNPC_out = seqNPC_in;
  assign EOI_out = EOI_in;
`ifdef MEM_STAGE_DEBUG_EN
  assign DEBUG_uop_out = DEBUG_uop;
  assign DEBUG_taken_out = DEBUG_taken;
`endif
  mem_bus_fsm u_fsm (
    .clk(CLK),
    .rst(RST),
    .rd(MEMctrl_in[MC_RD]),
    .wr(MEMctrl_in[MC_WR]),
    .io(MEMctrl_in[MC_IO]),
    .word(MEMctrl_in[MC_WORD]),
    .addr(addr),
    .wdata(wdata),
    .result(Result_in),
    .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .bus_req(bus_req),
    .bus_wr(bus_wr),
    .bus_io(bus_io),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .stall(stall_out),
    .data_out(Data_out)
  );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized transaction-level model of mem_stage with per-cycle comparison
module tb_mem_stage;
  logic CLK = 0, RST = 1;
  logic [4:0] Wr_id_in = 0;
  logic [7:0] Fmask_in = 0, Flags_in = 0, bus_rdata = 0, bus_wdata;
  logic [6:0] MEMctrl_in = 0;
  logic [15:0] Result_in = 0, Src1_in = 0, seqNPC_in = 0, bus_addr, seqNPC_out, Data_out;
  logic EOI_in = 0, bus_ack = 0, bus_req, bus_wr, bus_io, stall_out, EOI_out;
  logic [4:0] Wr_id_out;
  logic [7:0] Fmask_out, Flags_out;
`ifdef MEM_STAGE_DEBUG_EN
  logic [38:0] DEBUG_uop = 0, DEBUG_uop_out;
  logic DEBUG_taken = 0, DEBUG_taken_out;
`endif
  int tests = 0, fails = 0;

  typedef struct {
    bit stall, req, wr, io, chk_data, eoi;
    logic [15:0] addr, data, npc;
    logic [7:0] wdata, fm, fl;
    logic [4:0] wid;
  } exp_t;
  typedef struct {
    bit stall, req, wr, io;
    logic [15:0] addr, data;
    logic [7:0] wdata;
  } obs_t;
  exp_t expq[$];
  obs_t log_q[$];

  mem_stage dut (
    .CLK(CLK), .RST(RST), .Wr_id_in(Wr_id_in), .Fmask_in(Fmask_in), .Flags_in(Flags_in),
    .MEMctrl_in(MEMctrl_in), .Result_in(Result_in), .Src1_in(Src1_in), .seqNPC_in(seqNPC_in),
    .EOI_in(EOI_in), .bus_req(bus_req), .bus_wr(bus_wr), .bus_io(bus_io), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall_out(stall_out),
`ifdef MEM_STAGE_DEBUG_EN
    .DEBUG_uop(DEBUG_uop), .DEBUG_uop_out(DEBUG_uop_out),
    .DEBUG_taken(DEBUG_taken), .DEBUG_taken_out(DEBUG_taken_out),
`endif
    .Wr_id_out(Wr_id_out), .Fmask_out(Fmask_out), .Flags_out(Flags_out),
    .seqNPC_out(seqNPC_out), .EOI_out(EOI_out), .Data_out(Data_out)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(string n, logic [15:0] a, logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  // compare DUT against the model mid-cycle whenever an expectation is queued
  always @(negedge CLK) if (expq.size() > 0) begin
    exp_t e;
    obs_t o;
    e = expq.pop_front();
    chk("stall_out", stall_out, e.stall);
    chk("bus_req", bus_req, e.req);
    if (e.req) begin
      chk("bus_addr", bus_addr, e.addr);
      chk("bus_wdata", bus_wdata, e.wdata);
      chk("bus_wr", bus_wr, e.wr);
      chk("bus_io", bus_io, e.io);
    end
    if (e.chk_data) chk("Data_out", Data_out, e.data);
    chk("Wr_id_out", Wr_id_out, e.wid);
    chk("Fmask_out", Fmask_out, e.fm);
    chk("Flags_out", Flags_out, e.fl);
    chk("seqNPC_out", seqNPC_out, e.npc);
    chk("EOI_out", EOI_out, e.eoi);
    o.stall = stall_out; o.req = bus_req; o.wr = bus_wr; o.io = bus_io;
    o.addr = bus_addr; o.data = Data_out; o.wdata = bus_wdata;
    log_q.push_back(o);
  end

  // one instruction: wl/wh bus wait cycles before the low/high byte ack
  task automatic do_op(input logic [6:0] ctrl, input logic [15:0] res, src1, input int wl, wh);
    exp_t e;
    logic rd, wr, io, word, acc;
    logic [15:0] a, wd;
    logic [7:0] lo, hi;
    int last;
    rd = ctrl[0]; wr = ctrl[1]; io = ctrl[2]; word = ctrl[3]; acc = rd | wr;
    a = ctrl[4] ? src1 : res;
    wd = ctrl[4] ? res : src1;
    lo = 8'($urandom); hi = 8'($urandom);
    @(posedge CLK); #1;
    MEMctrl_in = ctrl; Result_in = res; Src1_in = src1;
    Wr_id_in = 5'($urandom); Fmask_in = 8'($urandom); Flags_in = 8'($urandom);
    seqNPC_in = 16'($urandom); EOI_in = 1'($urandom);
    bus_ack = 1'($urandom); bus_rdata = 8'($urandom);
    e.wid = Wr_id_in; e.fm = Fmask_in; e.fl = Flags_in; e.npc = seqNPC_in; e.eoi = EOI_in;
    e.stall = acc; e.req = 0; e.wr = 0; e.io = 0; e.addr = 0; e.wdata = 0;
    e.chk_data = !acc; e.data = res;
    expq.push_back(e);
    if (acc) begin
      for (int p = 0; p < (word ? 2 : 1); p++) begin
        last = p ? wh : wl;
        for (int w = 0; w <= last; w++) begin
          @(posedge CLK); #1;
          bus_ack = (w == last);
          bus_rdata = (w == last) ? (p ? hi : lo) : 8'($urandom);
          e.stall = 1; e.req = 1; e.chk_data = 0;
          e.wr = wr & ~rd; e.io = io;
          e.addr = p ? 16'(a + 16'd1) : a;
          e.wdata = p ? wd[15:8] : wd[7:0];
          expq.push_back(e);
        end
      end
      @(posedge CLK); #1;
      bus_ack = 1'($urandom); bus_rdata = 8'($urandom);
      e.stall = 0; e.req = 0; e.chk_data = 1;
      e.data = rd ? (word ? {hi, lo} : {8'h00, lo}) : res;
      expq.push_back(e);
    end
  endtask

  task automatic settle();
    @(negedge CLK); #1;
  endtask

  initial begin
    Result_in = 16'hA5A5;
`ifdef MEM_STAGE_DEBUG_EN
    DEBUG_uop = 39'h12_3456_789A;
    DEBUG_taken = 1;
`endif
    #3;
    chk("rst bus_req", bus_req, 0);
    chk("rst stall", stall_out, 0);
    chk("rst Data_out", Data_out, 16'hA5A5);
    @(posedge CLK); #1;
    RST = 0;

    log_q.delete();
    do_op(7'b1100000, 16'h1234, 16'h0000, 0, 0);
    settle();
    chk("nonacc data", log_q[0].data, 16'h1234);
    chk("nonacc stall", log_q[0].stall, 0);
    chk("nonacc req", log_q[0].req, 0);

    log_q.delete();
    do_op(7'b0000001, 16'hC000, 16'h0000, 2, 0);
    settle();
    chk("bread cycles", 16'(log_q.size()), 5);
    chk("bread stalls", 16'(log_q[0].stall + log_q[1].stall + log_q[2].stall + log_q[3].stall + log_q[4].stall), 4);
    chk("bread addr", log_q[1].addr, 16'hC000);

    log_q.delete();
    MEMctrl_in = 7'b0000001; Result_in = 16'hC000;
    @(posedge CLK); #1; bus_ack = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1; bus_ack = 1; bus_rdata = 8'h5A;
    @(posedge CLK); #1; bus_ack = 0;
    #2 chk("bread done data", Data_out, 16'h005A);
    chk("bread done stall", stall_out, 0);

    log_q.delete();
    do_op(7'b0011010, 16'hBEEF, 16'hFFFF, 0, 0);
    settle();
    chk("wwr addr lo", log_q[1].addr, 16'hFFFF);
    chk("wwr wdata lo", log_q[1].wdata, 16'h00EF);
    chk("wwr addr hi", log_q[2].addr, 16'h0000);
    chk("wwr wdata hi", log_q[2].wdata, 16'h00BE);
    chk("wwr bus_wr", log_q[2].wr, 1);

    log_q.delete();
    do_op(7'b0000111, 16'h0040, 16'h0000, 1, 0);
    settle();
    chk("io bus_io", log_q[1].io, 1);
    chk("io bus_wr", log_q[1].wr, 0);

    @(posedge CLK); #1;
    MEMctrl_in = 7'b0001001; Result_in = 16'h4000; bus_ack = 0;
    @(posedge CLK); #1; bus_ack = 1; bus_rdata = 8'h11;
    @(posedge CLK); #1; bus_ack = 0;
    #2 chk("hi bus_req", bus_req, 1);
    chk("hi bus_addr", bus_addr, 16'h4001);
    RST = 1;
    #1 chk("async rst bus_req", bus_req, 0);
    @(posedge CLK); #1; bus_ack = 1;
    @(posedge CLK); #1;
    RST = 0; MEMctrl_in = 0; Result_in = 16'h1111; bus_ack = 1;
    #1 chk("post rst stall", stall_out, 0);
    chk("post rst req", bus_req, 0);
    chk("post rst data", Data_out, 16'h1111);
    @(posedge CLK); #1; bus_ack = 0;
    #1 chk("late ack req", bus_req, 0);
    chk("late ack stall", stall_out, 0);
    log_q.delete();
    do_op(7'b0000001, 16'h2222, 16'h0000, 0, 0);
    settle();
    chk("restart cycles", 16'(log_q.size()), 3);
    chk("restart addr", log_q[1].addr, 16'h2222);

    for (int i = 0; i < 300; i++)
      do_op(7'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    settle();
    settle();
    chk("queue drained", 16'(expq.size()), 0);

`ifdef MEM_STAGE_DEBUG_EN
    chk("dbg uop lo", DEBUG_uop_out[15:0], 16'h789A);
    chk("dbg uop mid", DEBUG_uop_out[31:16], 16'h3456);
    chk("dbg uop hi", {9'd0, DEBUG_uop_out[38:32]}, 16'h0012);
    chk("dbg taken", DEBUG_taken_out, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
